// File: rtl/axi_rdata_ctrl_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// axi_rdata_ctrl_pkg
// Shared AXI2AHB bridge constants: RRESP codes, R-channel FSM encoding and
// default widths.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
package axi_rdata_ctrl_pkg;

   // Default widths for the bridge data path
   localparam int DATA_W_DEF = 64;
   localparam int ID_W_DEF   = 4;
   localparam int LEN_W_DEF  = 8;

   // AXI RRESP encodings
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   // R-channel controller state encoding
   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ACTIVE = 2'd1;
   localparam logic [1:0] ST_DRAIN  = 2'd2;

endpackage : axi_rdata_ctrl_pkg
`default_nettype wire

// File: rtl/axi_rdata_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// axi_rdata_ctrl
// AXI R-channel generator downstream of the bridge read-data FIFO. Accepts a
// burst command, pops LEN+1 beats and presents them through a registered
// R output stage with full RREADY backpressure.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
module axi_rdata_ctrl
   import axi_rdata_ctrl_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ID_W   = ID_W_DEF,
   parameter int LEN_W  = LEN_W_DEF
) (
   input  logic              rclk,
   input  logic              resetn,
   // burst command
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [ID_W-1:0]   cmd_id,
   input  logic [LEN_W-1:0]  cmd_len,
   input  logic              cmd_err,
   // read-data FIFO
   input  logic              fifo_empty,
   input  logic [DATA_W-1:0] fifo_rd_data,
   output logic              fifo_rd_en,
   // AXI R channel
   output logic              rvalid,
   input  logic              rready,
   output logic [DATA_W-1:0] rdata,
   output logic [ID_W-1:0]   rid,
   output logic [1:0]        rresp,
   output logic              rlast
);

   localparam logic [LEN_W-1:0] LEN_ONE = {{(LEN_W-1){1'b0}}, 1'b1};

   logic [1:0]        state_q, state_d;
   logic [LEN_W-1:0]  len_q;
   logic [ID_W-1:0]   id_q;
   logic              err_q;
   logic [LEN_W-1:0]  pop_cnt_q;

   logic              rvalid_q;
   logic [DATA_W-1:0] rdata_q;
   logic [ID_W-1:0]   rid_q;
   logic [1:0]        rresp_q;
   logic              rlast_q;

   logic              pop;
   logic              last_pop;
   logic              cmd_accept;
   logic              final_hs;

   // Handshake and pop qualifiers; a pop only happens when the output
   // register is empty or is being emptied this cycle.
   always_comb begin
      cmd_ready  = (state_q == ST_IDLE);
      cmd_accept = cmd_ready & cmd_valid;
      pop        = (state_q == ST_ACTIVE) & ~fifo_empty & (~rvalid_q | rready);
      last_pop   = (pop_cnt_q == len_q);
      final_hs   = rvalid_q & rready & rlast_q;
   end

   // Burst FSM next-state
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (cmd_valid)       state_d = ST_ACTIVE;
         ST_ACTIVE: if (pop && last_pop) state_d = ST_DRAIN;
         ST_DRAIN:  if (final_hs)        state_d = ST_IDLE;
         default:                        state_d = ST_IDLE;
      endcase
   end

   // FSM state, latched command and pop counter; the counter is compared
   // before it increments so the len=255 wrap back to zero is harmless
   always_ff @(posedge rclk or negedge resetn) begin
      if (!resetn) begin
         state_q   <= ST_IDLE;
         len_q     <= '0;
         id_q      <= '0;
         err_q     <= 1'b0;
         pop_cnt_q <= '0;
      end else begin
         state_q <= state_d;
         if (cmd_accept) begin
            len_q     <= cmd_len;
            id_q      <= cmd_id;
            err_q     <= cmd_err;
            pop_cnt_q <= '0;
         end else if (pop) begin
            pop_cnt_q <= pop_cnt_q + LEN_ONE;
         end
      end
   end

   // Registered R output stage: load on pop, drop valid on an unrefilled
   // handshake, otherwise hold (covers the rvalid & !rready stall)
   always_ff @(posedge rclk or negedge resetn) begin
      if (!resetn) begin
         rvalid_q <= 1'b0;
         rdata_q  <= '0;
         rid_q    <= '0;
         rresp_q  <= RESP_OKAY;
         rlast_q  <= 1'b0;
      end else if (pop) begin
         rvalid_q <= 1'b1;
         rdata_q  <= fifo_rd_data;
         rid_q    <= id_q;
         rresp_q  <= err_q ? RESP_SLVERR : RESP_OKAY;
         rlast_q  <= last_pop;
      end else if (rvalid_q && rready) begin
         rvalid_q <= 1'b0;
      end
   end

   assign fifo_rd_en = pop;
   assign rvalid     = rvalid_q;
   assign rdata      = rdata_q;
   assign rid        = rid_q;
   assign rresp      = rresp_q;
   assign rlast      = rlast_q;

endmodule : axi_rdata_ctrl
`default_nettype wire

// File: tb/tb_axi_rdata_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_axi_rdata_ctrl
// Directed self-checking bench for axi_rdata_ctrl with a behavioural FIFO.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_axi_rdata_ctrl;

   logic        rclk = 1'b0;
   logic        resetn;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [3:0]  cmd_id;
   logic [7:0]  cmd_len;
   logic        cmd_err;
   logic        fifo_empty;
   logic [63:0] fifo_rd_data;
   logic        fifo_rd_en;
   logic        rvalid;
   logic        rready;
   logic [63:0] rdata;
   logic [3:0]  rid;
   logic [1:0]  rresp;
   logic        rlast;

   axi_rdata_ctrl dut (
      .rclk        (rclk),
      .resetn      (resetn),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_id      (cmd_id),
      .cmd_len     (cmd_len),
      .cmd_err     (cmd_err),
      .fifo_empty  (fifo_empty),
      .fifo_rd_data(fifo_rd_data),
      .fifo_rd_en  (fifo_rd_en),
      .rvalid      (rvalid),
      .rready      (rready),
      .rdata       (rdata),
      .rid         (rid),
      .rresp       (rresp),
      .rlast       (rlast)
   );

   always #5 rclk = ~rclk;

   // behavioural FIFO: writer is the stimulus, reader is the DUT
   logic [63:0] mem [0:1023];
   int          wr_ptr = 0;
   int          rd_ptr = 0;
   assign fifo_empty   = (rd_ptr == wr_ptr);
   assign fifo_rd_data = mem[rd_ptr];

   always @(posedge rclk or negedge resetn) begin
      if (!resetn)                         rd_ptr <= wr_ptr;
      else if (fifo_rd_en && !fifo_empty)  rd_ptr <= rd_ptr + 1;
   end

   // expected beat stream
   logic [63:0] exp_d[$];
   logic [3:0]  exp_id[$];
   logic [1:0]  exp_resp[$];
   logic        exp_last[$];

   int n_cmp = 0;
   int n_err = 0;
   int beats;
   int steps;
   bit saw_last;
   bit stall_prev;
   logic [63:0] p_rdata;
   logic [3:0]  p_rid;
   logic [1:0]  p_rresp;
   logic        p_rlast;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push_word(input logic [63:0] d);
      mem[wr_ptr] = d;
      wr_ptr      = wr_ptr + 1;
      exp_d.push_back(d);
   endtask

   // per-cycle checks at the negative edge
   task automatic mon();
      logic [63:0] d;
      if (rvalid && !rready) chk("nopop_backpressure", fifo_rd_en, 0);
      if (fifo_empty)        chk("nopop_empty", fifo_rd_en, 0);
      if (stall_prev) begin
         chk("hold_rvalid", rvalid, 1);
         chk("hold_rdata", rdata, p_rdata);
         chk("hold_rid", rid, p_rid);
         chk("hold_rresp", rresp, p_rresp);
         chk("hold_rlast", rlast, p_rlast);
      end
      if (rvalid && rready) begin
         chk("beat_expected", (exp_id.size() != 0 && exp_d.size() != 0), 1);
         if (exp_id.size() != 0 && exp_d.size() != 0) begin
            d = exp_d.pop_front();
            chk("beat_rdata", rdata, d);
            chk("beat_rid", rid, exp_id.pop_front());
            chk("beat_rresp", rresp, exp_resp.pop_front());
            chk("beat_rlast", rlast, exp_last.pop_front());
         end
         beats++;
         if (rlast) saw_last = 1'b1;
      end
      stall_prev = rvalid && !rready;
      p_rdata = rdata; p_rid = rid; p_rresp = rresp; p_rlast = rlast;
   endtask

   task automatic step();
      @(negedge rclk);
      mon();
      @(posedge rclk);
      #1;
   endtask

   task automatic send_cmd(input logic [3:0] id, input logic [7:0] len, input logic err);
      chk("cmd_ready_idle", cmd_ready, 1);
      for (int i = 0; i <= int'(len); i++) begin
         exp_id.push_back(id);
         exp_resp.push_back(err ? 2'b10 : 2'b00);
         exp_last.push_back(i == int'(len));
      end
      cmd_valid = 1'b1; cmd_id = id; cmd_len = len; cmd_err = err;
      beats = 0; saw_last = 1'b0;
      step();
      cmd_valid = 1'b0; cmd_id = 4'h0; cmd_len = 8'h00; cmd_err = 1'b0;
   endtask

   task automatic run_until_last(input int budget, output int n);
      n = 0;
      while (!saw_last && n < budget) begin
         step();
         n++;
      end
      chk("last_seen", saw_last, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      resetn = 1'b0; cmd_valid = 1'b0; cmd_id = '0; cmd_len = '0; cmd_err = 1'b0;
      rready = 1'b0; stall_prev = 1'b0; beats = 0; saw_last = 1'b0;
      repeat (3) @(posedge rclk);
      #1;
      // reset values
      chk("rst_cmd_ready", cmd_ready, 1);
      chk("rst_fifo_rd_en", fifo_rd_en, 0);
      chk("rst_rvalid", rvalid, 0);
      chk("rst_rdata", rdata, 0);
      chk("rst_rid", rid, 0);
      chk("rst_rresp", rresp, 0);
      chk("rst_rlast", rlast, 0);
      resetn = 1'b1;
      step();

      // 1: id=3 len=3, four back-to-back beats, busy command ignored
      for (int i = 0; i < 4; i++) push_word(64'hA0 + 64'(i));
      rready = 1'b1;
      send_cmd(4'd3, 8'd3, 1'b0);
      chk("t1_pop_first", fifo_rd_en, 1);
      chk("t1_rvalid_latency", rvalid, 0);
      cmd_valid = 1'b1; cmd_id = 4'd7; cmd_len = 8'd0;
      chk("t1_busy_cmd_ready", cmd_ready, 0);
      step();
      cmd_valid = 1'b0;
      chk("t1_rvalid_first", rvalid, 1);
      run_until_last(20, steps);
      chk("t1_cycles", steps + 1, 5);
      chk("t1_idle_after", cmd_ready, 1);
      chk("t1_beats", beats, 4);
      chk("t1_queue_drained", exp_id.size(), 0);

      // 2: len=0 err=1 single SLVERR beat
      push_word(64'h55);
      send_cmd(4'hC, 8'd0, 1'b1);
      run_until_last(20, steps);
      chk("t2_cycles", steps, 2);
      chk("t2_beats", beats, 1);
      chk("t2_idle_after", cmd_ready, 1);

      // 3: len=7 with rready toggling 1,0,0,1
      for (int i = 0; i < 8; i++) push_word(64'h100 + 64'(i));
      send_cmd(4'd2, 8'd7, 1'b0);
      for (int k = 0; k < 100 && !saw_last; k++) begin
         rready = (k % 4 == 0) || (k % 4 == 3);
         step();
      end
      rready = 1'b1;
      chk("t3_last_seen", saw_last, 1);
      chk("t3_beats", beats, 8);
      chk("t3_queue_drained", exp_d.size(), 0);

      // 4: len=3 with FIFO running dry after the 2nd beat
      push_word(64'hB0);
      push_word(64'hB1);
      send_cmd(4'd5, 8'd3, 1'b0);
      repeat (3) step();
      chk("t4_rvalid_drop", rvalid, 0);
      chk("t4_beats_before_stall", beats, 2);
      for (int i = 0; i < 5; i++) begin
         chk("t4_stall_no_pop", fifo_rd_en, 0);
         chk("t4_stall_busy", cmd_ready, 0);
         step();
      end
      push_word(64'hB2);
      push_word(64'hB3);
      run_until_last(20, steps);
      chk("t4_beats", beats, 4);

      // 5: len=255, 256 beats at full rate
      for (int i = 0; i < 256; i++) push_word(64'hF000_0000_0000_0000 + 64'(i));
      send_cmd(4'd1, 8'd255, 1'b0);
      run_until_last(400, steps);
      chk("t5_cycles", steps, 257);
      chk("t5_beats", beats, 256);
      chk("t5_idle_after", cmd_ready, 1);

      // 6: asynchronous reset during beat 2 of a len=5 burst
      for (int i = 0; i < 6; i++) push_word(64'h600 + 64'(i));
      send_cmd(4'd6, 8'd5, 1'b0);
      repeat (2) step();
      chk("t6_beat2_pre_reset", rdata, 64'h601);
      #2 resetn = 1'b0;
      #1;
      chk("t6_rst_rvalid", rvalid, 0);
      chk("t6_rst_rdata", rdata, 0);
      chk("t6_rst_rid", rid, 0);
      chk("t6_rst_rresp", rresp, 0);
      chk("t6_rst_rlast", rlast, 0);
      chk("t6_rst_cmd_ready", cmd_ready, 1);
      chk("t6_rst_fifo_rd_en", fifo_rd_en, 0);
      exp_d.delete(); exp_id.delete(); exp_resp.delete(); exp_last.delete();
      stall_prev = 1'b0;
      step();
      resetn = 1'b1;
      step();
      push_word(64'h901);
      push_word(64'h902);
      send_cmd(4'd9, 8'd1, 1'b0);
      run_until_last(20, steps);
      chk("t6_post_cycles", steps, 3);
      chk("t6_post_beats", beats, 2);
      chk("t6_post_idle", cmd_ready, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_axi_rdata_ctrl
`default_nettype wire
